// File: rtl/data_tap_sink.sv
// Purpose: samples tapped core bits and timestamps each value change; records are queued for a trace consumer.
// Latency: a tap_in change seen at edge E0 is written at E1; evt_valid rises the cycle after E1 (no fall-through).
// Backpressure: evt_valid/evt_ready drain; when the queue is full, new records are dropped and counted, and the next kept record is flagged ovf.
module data_tap_sink #(
  parameter int TAP_W = 2,
  parameter int TS_W  = 14,
  parameter int DEPTH = 8
) (
  input  logic                  clock,
  input  logic                  reset_n,
  input  logic                  enable,
  input  logic [TAP_W-1:0]      tap_in,
  output logic                  evt_valid,
  input  logic                  evt_ready,
  output logic [TS_W+TAP_W:0]   evt_data,
  output logic [7:0]            drop_cnt
);

  localparam int AW = $clog2(DEPTH);
  localparam int RW = 1 + TS_W + TAP_W;
  localparam logic [AW:0]   PTR_ONE  = 1;
  localparam logic [TS_W-1:0] TS_ONE = 1;
  localparam logic [7:0]    DROP_MAX = 8'hFF;
  localparam logic [7:0]    DROP_ONE = 8'h01;

  typedef logic [RW-1:0] rec_t;

  logic [TAP_W-1:0] tap_q;
  logic [TAP_W-1:0] tap_prev;
  logic             enable_q;
  logic [TS_W-1:0]  ts;
  logic             ovf_pend;
  logic [AW:0]      wr_ptr;
  logic [AW:0]      rd_ptr;
  rec_t             mem [DEPTH];

  logic             sync_evt;
  logic             chg_evt;
  logic             push_req;
  logic             push_ok;
  logic             push_fail;
  logic             pop;
  logic             empty;
  logic             full;
  logic [7:0]       drop_base;
  rec_t             push_rec;

  // Event detection, queue status and the record that would be written this cycle
  always_comb begin
    sync_evt  = enable && !enable_q;
    chg_evt   = enable && enable_q && (tap_q != tap_prev);
    push_req  = sync_evt || chg_evt;
    empty     = (wr_ptr == rd_ptr);
    full      = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    pop       = !empty && evt_ready;
    // A full queue still accepts a record when the head leaves in the same cycle
    push_ok   = push_req && (!full || pop);
    push_fail = push_req && !push_ok;
    // The sync cycle starts a fresh capture session: prior drops are forgotten
    drop_base = sync_evt ? 8'h00 : drop_cnt;
    push_rec  = {ovf_pend && !sync_evt, ts, tap_q};
    evt_valid = !empty;
    evt_data  = empty ? '0 : mem[rd_ptr[AW-1:0]];
  end

  // Input stage: single timing flop plus previous-value history, independent of enable
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      tap_q    <= '0;
      tap_prev <= '0;
      enable_q <= 1'b0;
    end else begin
      tap_q    <= tap_in;
      tap_prev <= tap_q;
      enable_q <= enable;
    end
  end

  // Timestamp counts enabled cycles from 0 and wraps silently; parked at 0 while disabled
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      ts <= '0;
    end else if (enable) begin
      ts <= ts + TS_ONE;
    end else begin
      ts <= '0;
    end
  end

  // Overflow flag and saturating drop counter track records lost to a full queue
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      ovf_pend <= 1'b0;
      drop_cnt <= 8'h00;
    end else begin
      if (push_ok) begin
        ovf_pend <= 1'b0;
      end else if (push_fail) begin
        ovf_pend <= 1'b1;
      end
      if (push_fail) begin
        drop_cnt <= (drop_base == DROP_MAX) ? DROP_MAX : drop_base + DROP_ONE;
      end else if (sync_evt) begin
        drop_cnt <= 8'h00;
      end
    end
  end

  // Queue pointers carry an extra wrap bit so full and empty are distinguishable
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push_ok) begin
        wr_ptr <= wr_ptr + PTR_ONE;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + PTR_ONE;
      end
    end
  end

  // Record storage; contents are only visible through evt_data when non-empty
  always_ff @(posedge clock) begin
    if (push_ok) begin
      mem[wr_ptr[AW-1:0]] <= push_rec;
    end
  end

endmodule

// File: tb/tb_data_tap_sink.sv
// Purpose: scoreboard bench for data_tap_sink with the default 2-bit tap, 14-bit timestamp, 8-deep queue.
// Latency: expected records are queued when a tap change is driven and compared when the DUT hands them over.
// Backpressure: evt_ready is stepped by the stimulus to fill, overflow and drain the queue.
module tb_data_tap_sink;

  logic        clock;
  logic        reset_n;
  logic        enable;
  logic [1:0]  tap_in;
  logic        evt_valid;
  logic        evt_ready;
  logic [16:0] evt_data;
  logic [7:0]  drop_cnt;

  int          n_cmp = 0;
  int          n_err = 0;
  int          en_cyc = 0;
  logic [16:0] sb[$];

  data_tap_sink dut (
    .clock     (clock),
    .reset_n   (reset_n),
    .enable    (enable),
    .tap_in    (tap_in),
    .evt_valid (evt_valid),
    .evt_ready (evt_ready),
    .evt_data  (evt_data),
    .drop_cnt  (drop_cnt)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [16:0] rec(input logic o, input int t, input logic [1:0] v);
    return {o, t[13:0], v};
  endfunction

  // Advance one clock; en_cyc follows the timestamp of the current cycle
  task automatic tick();
    @(posedge clock);
    if (!reset_n || !enable) en_cyc = 0;
    else en_cyc++;
    #1;
  endtask

  // Drive a new tap value; if it should survive, expect it one cycle later in timestamp
  task automatic drive_change(input logic [1:0] v, input logic keep, input logic o);
    tap_in = v;
    if (keep) sb.push_back(rec(o, en_cyc + 1, v));
  endtask

  task automatic do_reset(input logic [1:0] t, input logic r);
    reset_n   = 1'b0;
    enable    = 1'b0;
    tap_in    = t;
    evt_ready = r;
    sb.delete();
    repeat (2) @(posedge clock);
    #1;
    reset_n = 1'b1;
    en_cyc  = 0;
    tick();
    tick();
  endtask

  // Scoreboard: every record the consumer accepts must be the oldest expected one
  always @(negedge clock) begin
    if (reset_n && evt_valid && evt_ready) begin
      if (sb.size() == 0) begin
        chk("unexpected_rec", {31'b0, evt_valid}, 32'd0);
      end else begin
        logic [16:0] e;
        e = sb.pop_front();
        chk("rec", {15'b0, evt_data}, {15'b0, e});
      end
    end
  end

  initial begin
    reset_n   = 1'b0;
    enable    = 1'b0;
    tap_in    = 2'b00;
    evt_ready = 1'b0;
    #1;
    chk("rst_valid", {31'b0, evt_valid}, 32'd0);
    chk("rst_drop", {24'b0, drop_cnt}, 32'd0);
    chk("rst_data", {15'b0, evt_data}, 32'd0);

    // A: single sync record, nothing after
    do_reset(2'b10, 1'b1);
    chk("A_idle_valid", {31'b0, evt_valid}, 32'd0);
    chk("A_idle_data", {15'b0, evt_data}, 32'd0);
    enable = 1'b1;
    sb.push_back(rec(1'b0, 0, 2'b10));
    chk("A_c0_valid", {31'b0, evt_valid}, 32'd0);
    tick();
    chk("A_c1_valid", {31'b0, evt_valid}, 32'd1);
    repeat (6) tick();
    chk("A_sb_left", 32'(sb.size()), 32'd0);
    chk("A_end_valid", {31'b0, evt_valid}, 32'd0);

    // B: change driven in cycle 4 gets ts=5, held value produces nothing more
    do_reset(2'b00, 1'b1);
    enable = 1'b1;
    sb.push_back(rec(1'b0, 0, 2'b00));
    repeat (4) tick();
    drive_change(2'b01, 1'b1, 1'b0);
    repeat (8) tick();
    chk("B_sb_left", 32'(sb.size()), 32'd0);
    chk("B_end_valid", {31'b0, evt_valid}, 32'd0);

    // C: sync + 10 changes with no consumer, 3 dropped, then ovf marks the next record
    do_reset(2'b00, 1'b0);
    enable = 1'b1;
    sb.push_back(rec(1'b0, 0, 2'b00));
    for (int k = 0; k < 10; k++) begin
      drive_change((k % 2) ? 2'b10 : 2'b01, k < 7, 1'b0);
      tick();
    end
    tick();
    chk("C_drop", {24'b0, drop_cnt}, 32'd3);
    chk("C_full_valid", {31'b0, evt_valid}, 32'd1);
    chk("C_head", {15'b0, evt_data}, {15'b0, sb[0]});
    evt_ready = 1'b1;
    repeat (8) tick();
    chk("C_drained_valid", {31'b0, evt_valid}, 32'd0);
    chk("C_drained_data", {15'b0, evt_data}, 32'd0);
    chk("C_drop_kept", {24'b0, drop_cnt}, 32'd3);
    chk("C_sb_left", 32'(sb.size()), 32'd0);
    drive_change(2'b01, 1'b1, 1'b1);
    tick();
    drive_change(2'b11, 1'b1, 1'b0);
    repeat (5) tick();
    chk("C_ovf_sb_left", 32'(sb.size()), 32'd0);

    // D: full queue, pop and push in the same cycle
    do_reset(2'b00, 1'b0);
    enable = 1'b1;
    sb.push_back(rec(1'b0, 0, 2'b00));
    for (int k = 0; k < 7; k++) begin
      drive_change((k % 2) ? 2'b10 : 2'b01, 1'b1, 1'b0);
      tick();
    end
    tick();
    chk("D_full_valid", {31'b0, evt_valid}, 32'd1);
    chk("D_full_drop", {24'b0, drop_cnt}, 32'd0);
    drive_change(2'b11, 1'b1, 1'b0);
    tick();
    evt_ready = 1'b1;
    tick();
    evt_ready = 1'b0;
    chk("D_drop_after", {24'b0, drop_cnt}, 32'd0);
    chk("D_sb_after", 32'(sb.size()), 32'd8);
    evt_ready = 1'b1;
    repeat (10) tick();
    chk("D_sb_left", 32'(sb.size()), 32'd0);
    chk("D_end_valid", {31'b0, evt_valid}, 32'd0);

    // E: disable with records queued, drain them, then re-enable
    do_reset(2'b00, 1'b0);
    enable = 1'b1;
    sb.push_back(rec(1'b0, 0, 2'b00));
    for (int k = 0; k < 9; k++) begin
      drive_change((k % 2) ? 2'b10 : 2'b01, k < 7, 1'b0);
      tick();
    end
    tick();
    chk("E_drop", {24'b0, drop_cnt}, 32'd2);
    evt_ready = 1'b1;
    repeat (5) tick();
    evt_ready = 1'b0;
    chk("E_sb_three", 32'(sb.size()), 32'd3);
    enable = 1'b0;
    tap_in = 2'b11;
    tick();
    tap_in = 2'b00;
    tick();
    tap_in = 2'b10;
    repeat (3) tick();
    chk("E_dis_drop", {24'b0, drop_cnt}, 32'd2);
    chk("E_dis_valid", {31'b0, evt_valid}, 32'd1);
    evt_ready = 1'b1;
    repeat (5) tick();
    chk("E_dis_sb_left", 32'(sb.size()), 32'd0);
    chk("E_dis_end_valid", {31'b0, evt_valid}, 32'd0);
    evt_ready = 1'b0;
    enable = 1'b1;
    sb.push_back(rec(1'b0, 0, 2'b10));
    tick();
    chk("E_sync_drop", {24'b0, drop_cnt}, 32'd0);
    chk("E_sync_valid", {31'b0, evt_valid}, 32'd1);
    chk("E_sync_rec", {15'b0, evt_data}, {15'b0, rec(1'b0, 0, 2'b10)});

    // F: asynchronous reset with a full queue and a non-zero drop count
    for (int k = 0; k < 8; k++) begin
      tap_in = (k % 2) ? 2'b10 : 2'b01;
      tick();
    end
    tick();
    chk("F_pre_drop", {24'b0, drop_cnt}, 32'd1);
    chk("F_pre_valid", {31'b0, evt_valid}, 32'd1);
    #3;
    reset_n = 1'b0;
    enable  = 1'b0;
    #1;
    chk("F_rst_valid", {31'b0, evt_valid}, 32'd0);
    chk("F_rst_drop", {24'b0, drop_cnt}, 32'd0);
    chk("F_rst_data", {15'b0, evt_data}, 32'd0);
    sb.delete();
    @(posedge clock);
    #1;
    reset_n = 1'b1;
    en_cyc  = 0;
    evt_ready = 1'b1;
    tick();
    tick();
    chk("F_post_valid", {31'b0, evt_valid}, 32'd0);
    sb.push_back(rec(1'b0, 0, 2'b10));
    enable = 1'b1;
    repeat (4) tick();
    chk("F_sb_left", 32'(sb.size()), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
